// File: rtl/wb_pkg.sv
// Shared types and helpers for the register-file writeback path.
package wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned WB_XLEN    = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [WB_XLEN-1:0]    data;
  } wb_req_t;

  function automatic logic is_x0(input logic [REG_ADDR_W-1:0] rd);
    return rd == '0;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests for long-latency results.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  wb_req_t       wdata_i,
  input  logic          pop_i,
  output wb_req_t       rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [PtrW:0] count_o
);

  wb_req_t         mem_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            push_ok, pop_ok;

  assign full_o  = (count_q == (PtrW + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    push_ok = push_i && !full_o;
    pop_ok  = pop_i && !empty_o;
    wptr_d  = push_ok ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d  = pop_ok ? rptr_q + PtrW'(1) : rptr_q;
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; the count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/rf_writeback.sv
// Register-file write-port arbiter: ALU results first, then queued LSU/DIV results,
// plus the pending-destination scoreboard used by issue to stall on in-flight operands.
module rf_writeback
  import wb_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid_i,
  input  logic [REG_ADDR_W-1:0] alu_rd_i,
  input  logic [XLEN-1:0]       alu_data_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [REG_ADDR_W-1:0] lsu_rd_i,
  input  logic [XLEN-1:0]       lsu_data_i,
  input  logic                  div_valid_i,
  output logic                  div_ready_o,
  input  logic [REG_ADDR_W-1:0] div_rd_i,
  input  logic [XLEN-1:0]       div_data_i,
  input  logic                  pend_set_i,
  input  logic [REG_ADDR_W-1:0] pend_rd_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  output logic                  rs1_busy_o,
  output logic                  rs2_busy_o,
  output logic                  rf_wr_en_o,
  output logic [REG_ADDR_W-1:0] rf_rd_addr_o,
  output logic [XLEN-1:0]       rf_data_o,
  output logic                  queue_full_o
);

  localparam int unsigned CntW    = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned NumRegs = 2 ** REG_ADDR_W;

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  wb_req_t         push_req, head_req, sel_req;
  logic            alu_wr, lsu_fire, div_fire;

  logic                  rf_wr_en_d, rf_wr_en_q;
  logic [REG_ADDR_W-1:0] rf_rd_addr_d, rf_rd_addr_q;
  logic [XLEN-1:0]       rf_data_d, rf_data_q;
  logic [NumRegs-1:0]    pend_d, pend_q, pend_set_mask, pend_clr_mask;

  // Readiness depends only on the registered count: a same-cycle pop never frees a slot.
  assign lsu_ready_o  = !fifo_full;
  assign div_ready_o  = !fifo_full && !lsu_valid_i;
  assign queue_full_o = (fifo_count == CntW'(QUEUE_DEPTH));

  always_comb begin
    lsu_fire      = lsu_valid_i && lsu_ready_o;
    div_fire      = div_valid_i && div_ready_o;
    push_req.rd   = lsu_valid_i ? lsu_rd_i : div_rd_i;
    push_req.data = lsu_valid_i ? lsu_data_i : div_data_i;
    // x0 results still handshake but are swallowed here.
    fifo_push     = (lsu_fire && !is_x0(lsu_rd_i)) || (div_fire && !is_x0(div_rd_i));
  end

  wb_fifo #(
    .Depth (QUEUE_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (push_req),
    .pop_i   (fifo_pop),
    .rdata_o (head_req),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    alu_wr       = alu_valid_i && !is_x0(alu_rd_i);
    fifo_pop     = !fifo_empty && !alu_wr;
    sel_req.rd   = alu_wr ? alu_rd_i : head_req.rd;
    sel_req.data = alu_wr ? alu_data_i : head_req.data;
    rf_wr_en_d   = alu_wr || fifo_pop;
    rf_rd_addr_d = rf_wr_en_d ? sel_req.rd : rf_rd_addr_q;
    rf_data_d    = rf_wr_en_d ? sel_req.data : rf_data_q;
  end

  // A set in the same cycle as a clear of the same register must win.
  always_comb begin
    pend_clr_mask = rf_wr_en_d ? (NumRegs'(1) << sel_req.rd) : '0;
    pend_set_mask = (pend_set_i && !is_x0(pend_rd_i)) ? (NumRegs'(1) << pend_rd_i) : '0;
    pend_d        = (pend_q & ~pend_clr_mask) | pend_set_mask;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_wr_en_q   <= 1'b0;
      rf_rd_addr_q <= '0;
      rf_data_q    <= '0;
      pend_q       <= '0;
    end else begin
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_addr_q <= rf_rd_addr_d;
      rf_data_q    <= rf_data_d;
      pend_q       <= pend_d;
    end
  end

  assign rf_wr_en_o   = rf_wr_en_q;
  assign rf_rd_addr_o = rf_rd_addr_q;
  assign rf_data_o    = rf_data_q;

  assign rs1_busy_o = !is_x0(rs1_addr_i) && pend_q[rs1_addr_i];
  assign rs2_busy_o = !is_x0(rs2_addr_i) && pend_q[rs2_addr_i];

endmodule

// File: tb/tb_rf_writeback.sv
// Scoreboard bench for rf_writeback: stimulus queues expected writes, a monitor checks them.
module tb_rf_writeback;
  import wb_pkg::*;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned QUEUE_DEPTH = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  logic            clk, rst_n;
  logic            alu_valid_i, lsu_valid_i, div_valid_i, pend_set_i;
  logic [4:0]      alu_rd_i, lsu_rd_i, div_rd_i, pend_rd_i, rs1_addr_i, rs2_addr_i;
  logic [XLEN-1:0] alu_data_i, lsu_data_i, div_data_i;
  logic            lsu_ready_o, div_ready_o, rs1_busy_o, rs2_busy_o;
  logic            rf_wr_en_o, queue_full_o;
  logic [4:0]      rf_rd_addr_o;
  logic [XLEN-1:0] rf_data_o;

  rf_writeback #(
    .XLEN        (XLEN),
    .QUEUE_DEPTH (QUEUE_DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid_i  (alu_valid_i),
    .alu_rd_i     (alu_rd_i),
    .alu_data_i   (alu_data_i),
    .lsu_valid_i  (lsu_valid_i),
    .lsu_ready_o  (lsu_ready_o),
    .lsu_rd_i     (lsu_rd_i),
    .lsu_data_i   (lsu_data_i),
    .div_valid_i  (div_valid_i),
    .div_ready_o  (div_ready_o),
    .div_rd_i     (div_rd_i),
    .div_data_i   (div_data_i),
    .pend_set_i   (pend_set_i),
    .pend_rd_i    (pend_rd_i),
    .rs1_addr_i   (rs1_addr_i),
    .rs2_addr_i   (rs2_addr_i),
    .rs1_busy_o   (rs1_busy_o),
    .rs2_busy_o   (rs2_busy_o),
    .rf_wr_en_o   (rf_wr_en_o),
    .rf_rd_addr_o (rf_rd_addr_o),
    .rf_data_o    (rf_data_o),
    .queue_full_o (queue_full_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data, input int at);
    exp_q.push_back('{rd: rd, data: data, cyc: at});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid_i = 1'b0;
    lsu_valid_i = 1'b0;
    div_valid_i = 1'b0;
    pend_set_i  = 1'b0;
  endtask

  // Every RF write must match the head of the expected queue, including its cycle.
  always @(negedge clk) begin
    if (rf_wr_en_o === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got x%0d=0x%0h at cycle %0d, expected no write",
                 rf_rd_addr_o, rf_data_o, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (rf_rd_addr_o !== mon_e.rd || rf_data_o !== mon_e.data || cyc != mon_e.cyc) begin
          fails++;
          $display("FAIL rf_write: got x%0d=0x%0h at cycle %0d, expected x%0d=0x%0h at cycle %0d",
                   rf_rd_addr_o, rf_data_o, cyc, mon_e.rd, mon_e.data, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    int c0;

    // Reset held two cycles with every valid high.
    rst_n = 1'b0;
    alu_valid_i = 1'b1; alu_rd_i = 5'd9;  alu_data_i = 32'h9999_0000;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd10; lsu_data_i = 32'h1010_0000;
    div_valid_i = 1'b1; div_rd_i = 5'd11; div_data_i = 32'h1111_0000;
    pend_set_i  = 1'b1; pend_rd_i = 5'd12;
    rs1_addr_i  = 5'd12; rs2_addr_i = 5'd0;
    step();
    step();
    rst_n = 1'b1;
    idle();
    #1;
    check_bit("reset_wr_en", rf_wr_en_o, 1'b0);
    check_word("reset_data", rf_data_o, 32'h0);
    check_word("reset_addr", {27'b0, rf_rd_addr_o}, 32'h0);
    check_bit("reset_rs1_busy", rs1_busy_o, 1'b0);
    check_bit("reset_lsu_ready", lsu_ready_o, 1'b1);
    check_bit("reset_div_ready", div_ready_o, 1'b1);
    check_bit("reset_queue_full", queue_full_o, 1'b0);
    repeat (2) step();

    // ALU beats a same-cycle LSU result.
    step(); c0 = cyc;
    alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'hA5A5_A5A5;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd6; lsu_data_i = 32'h1234_5678;
    expect_wr(5'd5, 32'hA5A5_A5A5, c0 + 1);
    expect_wr(5'd6, 32'h1234_5678, c0 + 2);
    #1;
    check_bit("prio_lsu_ready", lsu_ready_o, 1'b1);
    check_bit("prio_div_ready_blocked_by_lsu", div_ready_o, 1'b0);
    step(); idle();
    repeat (4) step();

    // Fill the FIFO behind a busy ALU, then drain in order.
    step(); c0 = cyc;
    for (int i = 0; i < 5; i++) begin
      alu_valid_i = 1'b1; alu_rd_i = 5'(20 + i); alu_data_i = 32'h1000 + 32'(i);
      expect_wr(5'(20 + i), 32'h1000 + 32'(i), c0 + i + 1);
      if (i < 4) begin
        div_valid_i = 1'b1; div_rd_i = 5'(i + 1); div_data_i = 32'hD000 + 32'(i + 1);
      end else begin
        div_valid_i = 1'b0;
      end
      #1;
      if (i < 4) begin
        check_bit("fill_div_ready", div_ready_o, 1'b1);
        check_bit("fill_not_full", queue_full_o, 1'b0);
      end else begin
        check_bit("full_queue_full", queue_full_o, 1'b1);
        check_bit("full_div_ready", div_ready_o, 1'b0);
        check_bit("full_lsu_ready", lsu_ready_o, 1'b0);
      end
      step();
    end
    idle();
    for (int i = 0; i < 4; i++) expect_wr(5'(i + 1), 32'hD000 + 32'(i + 1), c0 + 6 + i);
    #1;
    check_bit("drain_first_still_full", queue_full_o, 1'b1);
    step();
    check_bit("drain_not_full", queue_full_o, 1'b0);
    check_bit("drain_div_ready", div_ready_o, 1'b1);
    repeat (5) step();

    // x0 LSU result is consumed without occupying a slot; ALU x0 does not block pops.
    step(); c0 = cyc;
    for (int i = 0; i < 3; i++) begin
      alu_valid_i = 1'b1; alu_rd_i = 5'(25 + i); alu_data_i = 32'h2500 + 32'(i * 256);
      div_valid_i = 1'b1; div_rd_i = 5'(8 + i); div_data_i = 32'h80 + 32'(i * 16);
      expect_wr(5'(25 + i), 32'h2500 + 32'(i * 256), c0 + i + 1);
      step();
    end
    div_valid_i = 1'b0;
    alu_rd_i = 5'd28; alu_data_i = 32'h2800;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd0; lsu_data_i = 32'hFFFF_FFFF;
    expect_wr(5'd28, 32'h2800, c0 + 4);
    #1;
    check_bit("x0_lsu_ready", lsu_ready_o, 1'b1);
    step();
    alu_rd_i = 5'd29; alu_data_i = 32'h2900;
    lsu_rd_i = 5'd11; lsu_data_i = 32'hB0;
    expect_wr(5'd29, 32'h2900, c0 + 5);
    #1;
    check_bit("x0_count_unchanged", queue_full_o, 1'b0);
    check_bit("x0_next_lsu_ready", lsu_ready_o, 1'b1);
    step();
    lsu_valid_i = 1'b0;
    alu_rd_i = 5'd0; alu_data_i = 32'hDEAD;
    expect_wr(5'd8, 32'h80, c0 + 6);
    expect_wr(5'd9, 32'h90, c0 + 7);
    expect_wr(5'd10, 32'hA0, c0 + 8);
    expect_wr(5'd11, 32'hB0, c0 + 9);
    #1;
    check_bit("x0_fourth_push_full", queue_full_o, 1'b1);
    step(); idle();
    check_bit("x0_drain_not_full", queue_full_o, 1'b0);
    repeat (5) step();

    // Scoreboard set, then cleared by the matching LSU write.
    step(); c0 = cyc;
    pend_set_i = 1'b1; pend_rd_i = 5'd7; rs1_addr_i = 5'd7; rs2_addr_i = 5'd0;
    #1;
    check_bit("sb_not_yet_busy", rs1_busy_o, 1'b0);
    step();
    pend_set_i = 1'b0;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd7; lsu_data_i = 32'h77;
    expect_wr(5'd7, 32'h77, c0 + 3);
    #1;
    check_bit("sb_rs1_busy", rs1_busy_o, 1'b1);
    check_bit("sb_x0_never_busy", rs2_busy_o, 1'b0);
    step(); idle();
    check_bit("sb_still_busy", rs1_busy_o, 1'b1);
    step();
    step();
    check_bit("sb_cleared", rs1_busy_o, 1'b0);

    // Set coinciding with the clear keeps the bit.
    step(); c0 = cyc;
    pend_set_i = 1'b1; pend_rd_i = 5'd7; rs2_addr_i = 5'd7;
    step();
    pend_set_i = 1'b0;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd7; lsu_data_i = 32'h71;
    expect_wr(5'd7, 32'h71, c0 + 3);
    #1;
    check_bit("sbw_busy", rs1_busy_o, 1'b1);
    step();
    lsu_valid_i = 1'b0;
    pend_set_i = 1'b1; pend_rd_i = 5'd7;
    step(); idle();
    step();
    check_bit("sbw_set_wins_rs1", rs1_busy_o, 1'b1);
    check_bit("sbw_set_wins_rs2", rs2_busy_o, 1'b1);
    repeat (2) step();

    // Reset with three results queued discards them.
    step(); c0 = cyc;
    for (int i = 0; i < 3; i++) begin
      pend_set_i = (i == 0); pend_rd_i = 5'd3;
      alu_valid_i = 1'b1; alu_rd_i = 5'(12 + 2 * i); alu_data_i = 32'hC00 + 32'(i);
      div_valid_i = 1'b1; div_rd_i = 5'(13 + 2 * i); div_data_i = 32'hE00 + 32'(i);
      expect_wr(5'(12 + 2 * i), 32'hC00 + 32'(i), c0 + i + 1);
      step();
    end
    idle();
    rs2_addr_i = 5'd3;
    rst_n = 1'b0;
    #1;
    check_bit("midrst_pre_busy_rs2", rs2_busy_o, 1'b1);
    check_bit("midrst_pre_busy_rs1", rs1_busy_o, 1'b1);
    step();
    rst_n = 1'b1;
    #1;
    check_bit("midrst_wr_en", rf_wr_en_o, 1'b0);
    check_bit("midrst_queue_full", queue_full_o, 1'b0);
    check_bit("midrst_rs1_busy", rs1_busy_o, 1'b0);
    check_bit("midrst_rs2_busy", rs2_busy_o, 1'b0);
    check_bit("midrst_lsu_ready", lsu_ready_o, 1'b1);
    check_bit("midrst_div_ready", div_ready_o, 1'b1);
    repeat (8) step();

    check_word("leftover_expected_writes", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rf_writeback.md
# rf_writeback

Writeback arbiter driving the integer register file's single write port (write enable, 5-bit destination, 32-bit data). It merges single-cycle ALU results with long-latency LSU and divider results, buffering the latter in a small FIFO. It also keeps a pending-register scoreboard so issue logic can stall on operands still in flight. It sits between the execute/memory units and the register file, as the producer end of the register-file write interface.

## Interface
Parameters:
- XLEN, 32: data width.
- QUEUE_DEPTH, 4: long-latency result FIFO entries. Power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- alu_valid_i  in  1  ALU result valid; always accepted, no ready.
- alu_rd_i  in  5  ALU destination register.
- alu_data_i  in  XLEN  ALU result.
- lsu_valid_i  in  1  load result valid.
- lsu_ready_o  out  1  load result accepted this cycle when high with valid.
- lsu_rd_i  in  5  load destination.
- lsu_data_i  in  XLEN  load data.
- div_valid_i  in  1  divider result valid.
- div_ready_o  out  1  divider result accepted this cycle when high with valid.
- div_rd_i  in  5  divider destination.
- div_data_i  in  XLEN  divider result.
- pend_set_i  in  1  issue of a long-latency op; marks pend_rd_i pending.
- pend_rd_i  in  5  destination being marked.
- rs1_addr_i, rs2_addr_i  in  5  issue-stage source addresses.
- rs1_busy_o, rs2_busy_o  out  1  source is pending; combinational from the scoreboard.
- rf_wr_en_o  out  1  register-file write enable; registered.
- rf_rd_addr_o  out  5  register-file write address; registered.
- rf_data_o  out  XLEN  register-file write data; registered.
- queue_full_o  out  1  FIFO holds QUEUE_DEPTH entries.

## Operation
- **Priority per cycle:** ALU > FIFO head. The FIFO pops only in a cycle with no ALU write.
- **FIFO push:** at most one push per cycle.
  - lsu_ready_o = !full.
  - div_ready_o = !full && !lsu_valid_i.
  - Both ready signals are computed from the current count. A pop in the same cycle does not free a slot for a push (no bypass).
- **x0 destination:** an ALU or FIFO-bound result with rd = 0 is consumed. It still handshakes (ready as above) but is never pushed and never produces rf_wr_en_o.
- **Write issue:** the selected result is registered onto rf_wr_en_o, rf_rd_addr_o and rf_data_o. With no selection, rf_wr_en_o = 0 and address/data hold their previous values.
- **Scoreboard:** a 32-bit pending bitmap.
  - pend_set_i sets bit pend_rd_i; bit 0 is never set.
  - The bit clears in the cycle its write is selected onto the RF port.
  - If a set and a clear hit the same register in the same cycle, the set wins.
- **Busy outputs:** rsN_busy_o = bitmap[rsN_addr_i]. x0 always reads not busy.
- **Reset (rst_n low at edge):** rf_wr_en_o=0, rf_rd_addr_o=0, rf_data_o=0, FIFO emptied, bitmap cleared, queue_full_o=0. Reset mid-operation discards all queued results; the ready outputs read 1 after reset.

## Timing
- ALU result valid in cycle N → rf_wr_en_o high in cycle N+1.
- LSU/DIV result accepted in cycle N → earliest pop decision in N+1 → rf_wr_en_o in N+2, delayed one cycle per intervening ALU write.
- FIFO order is strict first-in, first-out; entries never reorder.
- Full: count = QUEUE_DEPTH. Both ready signals are low. queue_full_o is high in the same cycle, derived from the count register.
- Empty with no ALU result: rf_wr_en_o = 0 in the next cycle.
- Pointer wrap: read/write pointers are log2(QUEUE_DEPTH) bits and wrap modulo depth. The count is one bit wider so full and empty are distinguishable.
- Scoreboard clear is visible on rsN_busy_o in the cycle after rf_wr_en_o is launched, i.e. the cycle the RF write lands.

## Structure
- Package wb_pkg:
  - constant REG_ADDR_W = 5.
  - typedef wb_req_t struct packed {rd[4:0], data[XLEN-1:0]}, using the XLEN default 32.
  - function is_x0(rd).
- Sub-module wb_fifo: synchronous FIFO of wb_req_t with push/pop/full/empty/count and synchronous active-low reset.
- The arbiter, scoreboard and output registers live in rf_writeback.

## Test plan
- **Reset:** hold rst_n low 2 cycles with all valids high → rf_wr_en_o=0, rf_data_o=0, rs1_busy_o=0, lsu_ready_o=1 after release.
- **ALU priority:** ALU (rd=5, 0xA5A5A5A5) and LSU (rd=6, 0x12345678) both valid in cycle 0 →
  - cycle 1: write x5=0xA5A5A5A5;
  - cycle 2: write x6=0x12345678.
- **Fill and drain:** ALU busy every cycle; push 4 DIV results (rd 1..4) → queue_full_o=1, div_ready_o=0. Drop ALU → writes x1..x4 in order on 4 consecutive cycles, then rf_wr_en_o=0.
- **x0 drop:** LSU (rd=0, 0xFFFFFFFF) → lsu_ready_o=1, FIFO count unchanged, no RF write.
- **Scoreboard:**
  - pend_set_i rd=7 → rs1_busy_o=1 for rs1_addr_i=7.
  - LSU rd=7 write lands → rs1_busy_o=0 the following cycle.
  - pend_set_i rd=7 coinciding with the clear → bit stays 1.
- **Mid-op reset:** 3 queued entries, assert rst_n for 1 cycle → no writes afterward, queue_full_o=0, all busy outputs 0.
